// File: rtl/cpu_pkg.sv
// Shared defaults, halt opcode and fetch-state encoding for inst_fetch_ctrl.
package cpu_pkg;

  localparam int AW_DEFAULT = 8;
  localparam int DW_DEFAULT = 16;

  localparam logic [3:0] HALT_OP = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_READ = 3'd2,
    S_WAIT = 3'd3,
    S_HOLD = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_ctrl_pc_counter.sv
// Program counter register: load on jump, increment (wrapping) otherwise.
module pc_counter #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  output logic [AW-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pc <= '0;
    else if (load) pc <= load_val;
    else if (inc)  pc <= pc + AW'(1);
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: SRAM read, IR handshake, pc advance/jump.
// Optional SRAM-response timeout with sticky fetch_err under `FETCH_TIMEOUT_EN.
//
// state | meaning
// IDLE  | stopped, waiting for start
// ADDR  | chip selected, sram_addr latched from pc
// READ  | one-cycle read strobe
// WAIT  | waiting for sram_is_coming
// HOLD  | instr presented to IR until ir_ready
import cpu_pkg::*;

module inst_fetch_ctrl #(
  parameter int AW      = AW_DEFAULT,
  parameter int DW      = DW_DEFAULT,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          halt,
  input  logic          jmp_en,
  input  logic [AW-1:0] jmp_addr,
  output logic          sram_rd,
  output logic          sram_cs_n,
  output logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_dout,
  input  logic          sram_is_coming,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  input  logic          ir_ready,
  output logic [AW-1:0] pc,
  output logic          busy
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic          fetch_err
`endif
);

  fetch_state_t state, state_nxt;
  logic handshake, is_halt_op, capture, timeout;

  assign handshake  = (state == S_HOLD) && ir_ready;
  assign is_halt_op = (instr[DW-1 -: 4] == HALT_OP);
  assign capture    = (state == S_WAIT) && sram_is_coming && !halt;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // Down-counter armed in READ; reaching zero in WAIT without data aborts.
  assign timeout = (state == S_WAIT) && !sram_is_coming && !halt && (wait_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state == S_READ)                         wait_cnt <= CW'(TIMEOUT - 1);
      else if (state == S_WAIT && wait_cnt != '0)  wait_cnt <= wait_cnt - CW'(1);
      if (timeout) fetch_err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      sram_addr <= '0;
      instr     <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_ADDR) sram_addr <= pc;
      if (capture)         instr     <= sram_dout;
    end
  end

  always_comb begin
    state_nxt   = state;
    sram_rd     = 1'b0;
    sram_cs_n   = 1'b1;
    instr_valid = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE: if (start) state_nxt = S_ADDR;
      S_ADDR: begin
        sram_cs_n = 1'b0;
        state_nxt = halt ? S_IDLE : S_READ;
      end
      S_READ: begin
        sram_cs_n = 1'b0;
        sram_rd   = 1'b1;
        state_nxt = halt ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        sram_cs_n = 1'b0;
        if (halt || timeout)     state_nxt = S_IDLE;
        else if (sram_is_coming) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        // A handshake always completes, even when halt arrives with it.
        if (handshake)   state_nxt = (halt || is_halt_op) ? S_IDLE : S_ADDR;
        else if (halt)   state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  pc_counter #(.AW(AW)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .inc      (handshake && !jmp_en),
    .load     (handshake && jmp_en),
    .load_val (jmp_addr),
    .pc       (pc)
  );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios plus random traffic vs. a fetch model.
module tb_inst_fetch_ctrl;
  localparam int AW = 8, DW = 16, TIMEOUT = 15;

  logic clk = 1'b0, rst = 1'b0;
  logic start = 0, halt = 0, jmp_en = 0, sram_is_coming = 0, ir_ready = 0;
  logic [AW-1:0] jmp_addr = '0;
  logic [DW-1:0] sram_dout = '0;
  logic sram_rd, sram_cs_n, instr_valid, busy;
  logic [AW-1:0] sram_addr, pc;
  logic [DW-1:0] instr;
`ifdef FETCH_TIMEOUT_EN
  logic fetch_err;
`endif

  always #5 clk = ~clk;

  inst_fetch_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .jmp_en(jmp_en), .jmp_addr(jmp_addr),
    .sram_rd(sram_rd), .sram_cs_n(sram_cs_n), .sram_addr(sram_addr), .sram_dout(sram_dout),
    .sram_is_coming(sram_is_coming), .instr(instr), .instr_valid(instr_valid),
    .ir_ready(ir_ready), .pc(pc), .busy(busy)
`ifdef FETCH_TIMEOUT_EN
    , .fetch_err(fetch_err)
`endif
  );

  int n_checks = 0, n_fail = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: which phase of a fetch we are in, plus architectural values.
  typedef enum {M_IDLE, M_ADDRESSING, M_STROBING, M_WAITING, M_PRESENTING} mphase_t;
  mphase_t m_phase;
  logic [AW-1:0] m_pc, m_addr;
  logic [DW-1:0] m_instr;
  int m_wcnt;
  bit m_err;
  logic [DW-1:0] mem [256];

  task automatic model_reset();
    m_phase = M_IDLE; m_pc = '0; m_addr = '0; m_instr = '0; m_wcnt = 0; m_err = 0;
  endtask

  task automatic model_step();
    case (m_phase)
      M_IDLE: if (start) m_phase = M_ADDRESSING;
      M_ADDRESSING: begin
        m_addr  = m_pc;
        m_phase = halt ? M_IDLE : M_STROBING;
      end
      M_STROBING: begin
        m_wcnt  = 0;
        m_phase = halt ? M_IDLE : M_WAITING;
      end
      M_WAITING: begin
        if (halt) m_phase = M_IDLE;
        else if (sram_is_coming) begin
          m_instr = sram_dout;
          m_phase = M_PRESENTING;
        end else begin
          m_wcnt++;
`ifdef FETCH_TIMEOUT_EN
          if (m_wcnt >= TIMEOUT) begin m_err = 1; m_phase = M_IDLE; end
`endif
        end
      end
      M_PRESENTING: begin
        if (ir_ready) begin
          m_pc    = jmp_en ? jmp_addr : AW'((int'(m_pc) + 1) % 256);
          m_phase = (halt || m_instr[15:12] == 4'hC) ? M_IDLE : M_ADDRESSING;
        end else if (halt) m_phase = M_IDLE;
      end
      default: m_phase = M_IDLE;
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",        busy,        m_phase != M_IDLE);
      check("sram_rd",     sram_rd,     m_phase == M_STROBING);
      check("sram_cs_n",   sram_cs_n,   !(m_phase inside {M_ADDRESSING, M_STROBING, M_WAITING}));
      check("instr_valid", instr_valid, m_phase == M_PRESENTING);
      check("pc",          pc,          m_pc);
      check("instr",       instr,       m_instr);
      check("sram_addr",   sram_addr,   m_addr);
`ifdef FETCH_TIMEOUT_EN
      check("fetch_err",   fetch_err,   m_err);
`endif
    end
  end

  // Drive one cycle's inputs, advance the model, land at negedge+1 of the next cycle.
  task automatic cyc(input bit s, h, je, input logic [AW-1:0] ja, input bit co,
                     input logic [DW-1:0] d, input bit rdy);
    start = s; halt = h; jmp_en = je; jmp_addr = ja;
    sram_is_coming = co; sram_dout = d; ir_ready = rdy;
    model_step();
    @(negedge clk); #1;
  endtask

  task automatic go_wait();
    for (int i = 0; i < 8 && m_phase != M_WAITING; i++) cyc(1, 0, 0, 0, 0, 16'h0, 0);
    if (m_phase != M_WAITING) begin
      n_checks++; n_fail++;
      $display("FAIL reach_wait: phase %0d expected WAITING", m_phase);
    end
  endtask

  task automatic get_to_hold(input logic [DW-1:0] d);
    go_wait();
    cyc(0, 0, 0, 0, 1, d, 0);
  endtask

  logic [DW-1:0] prog [3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prog[0] = 16'h2100; prog[1] = 16'h9400; prog[2] = 16'hC000;
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? {4'hC, 12'($urandom)} : 16'($urandom);
    for (int i = 0; i < 3; i++) mem[i] = prog[i];
    model_reset();

    #2 rst = 1'b1;
    #10;
    check("rst_busy", busy, 0); check("rst_cs_n", sram_cs_n, 1); check("rst_rd", sram_rd, 0);
    check("rst_pc", pc, 0); check("rst_instr", instr, 0); check("rst_addr", sram_addr, 0);
    check("rst_valid", instr_valid, 0);
    @(negedge clk); #1;
    rst = 1'b0; chk_en = 1;
    cyc(0, 0, 0, 0, 0, 16'h0, 0);

    // Minimum latency and the three-instruction program.
    cyc(1, 0, 0, 0, 0, 16'h0, 0);
    check("lat_c1_rd", sram_rd, 0); check("lat_c1_cs", sram_cs_n, 0);
    cyc(0, 0, 0, 0, 0, 16'h0, 0);
    check("lat_c2_rd", sram_rd, 1); check("lat_c2_addr", sram_addr, 8'h00);
    cyc(0, 0, 0, 0, 0, 16'h0, 0);
    cyc(0, 0, 0, 0, 1, mem[m_addr], 0);
    check("lat_c4_valid", instr_valid, 1); check("prog_instr0", instr, prog[0]);
    cyc(0, 0, 0, 0, 0, 16'h0, 1);
    check("prog_pc1", pc, 8'h01); check("prog_valid_drop", instr_valid, 0);
    for (int k = 1; k < 3; k++) begin
      go_wait();
      cyc(0, 0, 0, 0, 1, mem[m_addr], 0);
      check("prog_instr", instr, prog[k]);
      cyc(0, 0, 0, 0, 0, 16'h0, 1);
      check("prog_pc", pc, 8'(k + 1));
    end
    check("prog_idle_busy", busy, 0);

    // IR stall: instr held for five cycles while data-valid noise is ignored.
    get_to_hold(16'h1234);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 1'($urandom), 16'($urandom), 0);
      check("stall_instr", instr, 16'h1234); check("stall_valid", instr_valid, 1);
      check("stall_pc", pc, 8'h03);
    end
    cyc(0, 0, 1, 8'hFF, 0, 16'h0, 1);
    check("jump_ff_pc", pc, 8'hFF);

    // Wrap from FF.
    go_wait();
    check("ff_addr", sram_addr, 8'hFF);
    cyc(0, 0, 0, 0, 1, 16'h2222, 0);
    cyc(0, 0, 0, 0, 0, 16'h0, 1);
    check("wrap_pc", pc, 8'h00);

    // Jump to 0x40.
    get_to_hold(16'h3333);
    cyc(0, 0, 1, 8'h40, 0, 16'h0, 1);
    go_wait();
    check("jump_addr", sram_addr, 8'h40);

    // Halt in WAIT beats arriving data; halt with handshake still advances pc.
    cyc(0, 1, 0, 0, 1, 16'h5555, 0);
    check("halt_wait_busy", busy, 0); check("halt_wait_valid", instr_valid, 0);
    check("halt_wait_pc", pc, 8'h40);
    get_to_hold(16'h4444);
    cyc(0, 1, 0, 0, 0, 16'h0, 1);
    check("halt_hs_pc", pc, 8'h41); check("halt_hs_busy", busy, 0);

`ifdef FETCH_TIMEOUT_EN
    go_wait();
    for (int i = 0; i < TIMEOUT - 1; i++) cyc(0, 0, 0, 0, 0, 16'h0, 0);
    check("to_pre_busy", busy, 1); check("to_pre_err", fetch_err, 0);
    cyc(0, 0, 0, 0, 0, 16'h0, 0);
    check("to_err", fetch_err, 1); check("to_busy", busy, 0); check("to_pc", pc, 8'h41);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit co;
      logic [DW-1:0] d;
      co = (m_phase == M_WAITING) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      d  = (m_phase == M_WAITING) ? mem[m_addr] : 16'($urandom);
      cyc(1'($urandom), $urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0,
          8'($urandom), co, d, 1'($urandom));
    end

    // Asynchronous reset in the middle of a fetch.
    go_wait();
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_busy", busy, 0); check("arst_pc", pc, 0); check("arst_addr", sram_addr, 0);
    check("arst_cs_n", sram_cs_n, 1); check("arst_instr", instr, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      bit co;
      co = (m_phase == M_WAITING) ? ($urandom_range(0, 1) == 0) : 1'b0;
      cyc(1'($urandom), $urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0,
          8'($urandom), co, mem[m_addr], 1'($urandom));
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
